// File: rtl/lsu_pkg.sv
// lsu_pkg: shared op encodings, FSM state type and access-flag bit indices for lsu_ctrl.
package lsu_pkg;
  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;
  localparam int NFLAG  = 8;
  localparam int FL_SB  = 0;
  localparam int FL_SH  = 1;
  localparam int FL_SW  = 2;
  localparam int FL_LB  = 3;
  localparam int FL_LH  = 4;
  localparam int FL_LBU = 5;
  localparam int FL_LHU = 6;
  localparam int FL_LW  = 7;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
endpackage

// File: rtl/lsu_decode.sv
// lsu_decode: combinational op legality, alignment and one-hot flag decode.
// Define LSU_MISALIGN_TRAP_EN to make misaligned half/word accesses illegal.
module lsu_decode
  import lsu_pkg::*;
(
  input  logic             we,
  input  logic [2:0]       op,
  input  logic [1:0]       addr_lo,
  output logic             legal,
  output logic [NFLAG-1:0] flags
);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic bad_op, misalign;
  always_comb begin
    bad_op         = op == 3'b011 || op[2:1] == 2'b11 || (we && op[2]);
    misalign       = (op[1:0] == 2'b01 && addr_lo[0]) || (op[1:0] == 2'b10 && addr_lo != 2'b00);
    legal          = !bad_op && !(TRAP && misalign);
    flags          = '0;
    flags[FL_SB]   = we && op == OP_B;
    flags[FL_SH]   = we && op == OP_H;
    flags[FL_SW]   = we && op == OP_W;
    flags[FL_LB]   = !we && op == OP_B;
    flags[FL_LH]   = !we && op == OP_H;
    flags[FL_LBU]  = !we && op == OP_BU;
    flags[FL_LHU]  = !we && op == OP_HU;
    flags[FL_LW]   = !we && op == OP_W;
  end
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller, IDLE -> ACCESS -> RESP.
// Build with LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              dm_ena,
  output logic              dm_r,
  output logic              dm_w,
  output logic              sb_flag,
  output logic              sh_flag,
  output logic              sw_flag,
  output logic              lb_flag,
  output logic              lh_flag,
  output logic              lbu_flag,
  output logic              lhu_flag,
  output logic              lw_flag,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);
  state_t            state_q, state_d;
  logic              we_q, we_d, err_q, err_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic              idle, dec_legal, unused_addr;
  logic [NFLAG-1:0]  dec_flags, flags;
  assign idle        = state_q == S_IDLE;
  assign unused_addr = ^req_addr[31:ADDR_W];
  // Legality is judged on the live request; flags on the latched one.
  lsu_decode u_dec (
    .we      (idle ? req_we : we_q),
    .op      (idle ? req_op : op_q),
    .addr_lo (req_addr[1:0]),
    .legal   (dec_legal),
    .flags   (dec_flags)
  );
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    dm_ena    = 1'b0;
    dm_r      = 1'b0;
    dm_w      = 1'b0;
    flags     = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          op_d    = req_op;
          addr_d  = req_addr[ADDR_W-1:0];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = !dec_legal;
          state_d = dec_legal ? S_ACCESS : S_RESP;
        end
      end
      S_ACCESS: begin
        dm_ena  = 1'b1;
        dm_r    = !we_q;
        dm_w    = we_q;
        flags   = dec_flags;
        rdata_d = we_q ? '0 : dm_rdata;
        state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = rsp_ready ? S_IDLE : S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dm_addr   = addr_q;
  assign dm_wdata  = wdata_q;
  assign sb_flag   = flags[FL_SB];
  assign sh_flag   = flags[FL_SH];
  assign sw_flag   = flags[FL_SW];
  assign lb_flag   = flags[FL_LB];
  assign lh_flag   = flags[FL_LH];
  assign lbu_flag  = flags[FL_LBU];
  assign lhu_flag  = flags[FL_LHU];
  assign lw_flag   = flags[FL_LW];
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, data-memory word-port address width driven on dm_addr.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  CPU access request valid.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready at rising clk.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_op  input  3  size/sign code: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  response valid.
REQ-011 SHALL have port rsp_ready  input  1  CPU consumes response.
REQ-012 SHALL have port rsp_rdata  output  32  load result, 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  illegal op or (per config) misaligned access.
REQ-014 SHALL have ports dm_ena, dm_r, dm_w  output  1 each  memory enable/read/write strobes.
REQ-015 SHALL have ports sb_flag, sh_flag, sw_flag, lb_flag, lh_flag, lbu_flag, lhu_flag, lw_flag  output  1 each  one-hot access-type flags.
REQ-016 SHALL have ports dm_addr  output  ADDR_W  = latched req_addr[ADDR_W-1:0]; dm_wdata  output  32  latched req_wdata; dm_rdata  input  32  memory read data.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-018 SHALL on accept latch we, op, addr, wdata; legal access goes to ACCESS, illegal goes directly to RESP with rsp_err=1.
REQ-019 SHALL treat req_op 011, 110, 111, and stores with req_op[2]=1, as illegal.
REQ-020 SHALL in ACCESS, for exactly one cycle, drive dm_ena=1, exactly one of dm_r/dm_w, and exactly one matching flag; all strobes and flags 0 in every other state.
REQ-021 SHALL capture dm_rdata into rsp_rdata at the rising edge ending ACCESS (loads only); the memory port's sign/zero extension is passed through unmodified.
REQ-022 SHALL assert rsp_valid throughout RESP, holding rsp_rdata/rsp_err stable until rsp_valid & rsp_ready, then return to IDLE.
REQ-023 SHALL give latency: accept at edge N, ACCESS during cycle N..N+1, rsp_valid high from edge N+1; back-to-back throughput one access per 3 cycles with rsp_ready held high.
REQ-024 SHALL ignore req_valid outside IDLE; a new request is never lost, because req_ready stays low.

Reset
REQ-025 SHALL on rst (any time, including mid-ACCESS) force IDLE and drive req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, all dm_* strobes/flags 0, dm_addr=0, dm_wdata=0.
REQ-026 SHALL discard any in-flight request on reset; no response is ever issued for it.

Configuration
REQ-027 SHALL, with LSU_MISALIGN_TRAP_EN defined, flag half accesses with addr[0]=1 and word accesses with addr[1:0]!=0 as errors that skip ACCESS (no memory strobe).
REQ-028 SHALL, without LSU_MISALIGN_TRAP_EN, perform misaligned accesses unchanged with rsp_err only for illegal ops.

Structure
REQ-029 SHALL place op encodings, FSM state enum and flag-index constants in shared package lsu_pkg.
REQ-030 SHALL place op legality/alignment/flag decode in combinational sub-module lsu_decode.

Verification
REQ-031 SHALL cover: reset, then SW addr 0x08 data 0xDEADBEEF -> one ACCESS cycle with dm_w=1, sw_flag=1, dm_addr=0x08; rsp_valid next edge, rsp_rdata=0, rsp_err=0.
REQ-032 SHALL cover: LW addr 0x08 with dm_rdata=0xDEADBEEF -> rsp_rdata=0xDEADBEEF, lw_flag only asserted.
REQ-033 SHALL cover: req_op=011 -> no strobe, rsp_err=1, rsp_rdata=0.
REQ-034 SHALL cover: LH addr 0x03 -> rsp_err=1, no strobe with LSU_MISALIGN_TRAP_EN; lh_flag access, rsp_err=0 without it.
REQ-035 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0; rst asserted mid-ACCESS -> all outputs reset immediately, no response.
